uart_tx_ctl_cfg: RTL and testbench

//  Parametrised UART transmit controller; successor to the fixed 8N1 transmitter.

---
 rtl/uart_tx_pkg.sv | 29 ++
 rtl/uart_os_cnt.sv | 31 +++
 rtl/uart_tx_ctl_cfg.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_ctl_cfg.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the configurable UART transmit controller.
//   tx_state_t      : FSM state encoding (IDLE..BRK)
//   PAR_*           : parity mode constants for the PARITY parameter
//   FRAME_*         : tx_frame_indicator encodings
//   frame_next()    : alternates the frame indicator between 01 and 10
package uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_BRK   = 3'd5
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [1:0] FRAME_IDLE = 2'b00;
  localparam logic [1:0] FRAME_01   = 2'b01;
  localparam logic [1:0] FRAME_10   = 2'b10;

  function automatic logic [1:0] frame_next(input logic [1:0] last);
    return (last == FRAME_10) ? FRAME_01 : FRAME_10;
  endfunction

endpackage

// File: rtl/uart_os_cnt.sv
// Oversample counter: loads OVERSAMPLE-1, decrements to 0 and holds there.
//   clk    : transmit clock
//   rst_n  : synchronous active-low reset (counter -> 0)
//   tick   : baud_en; the counter only moves on ticks
//   load   : reload OVERSAMPLE-1 on this tick (state entry / next bit)
//   done   : counter is 0, i.e. current tick is the last one of the bit
module uart_os_cnt #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic load,
  output logic done
);

  localparam int CW = $clog2(OVERSAMPLE);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)             cnt <= '0;
    else if (tick) begin
      if (load)             cnt <= CW'(OVERSAMPLE - 1);
      else if (cnt != '0)   cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/uart_tx_ctl_cfg.sv
// Configurable UART transmitter: pops characters from a FWFT FIFO and sends
// start, DATA_BITS data (LSB first), optional parity and STOP_BITS stop bits.
// Supports level-requested line break and back-to-back frames.
//   clk_tx / rst_clk_tx_n : clock, synchronous active-low reset
//   baud_en               : oversample tick, OVERSAMPLE per bit
//   char_fifo_empty/dout  : FIFO status and head word
//   char_fifo_rd_en       : one-cycle pop per character
//   tx_break              : hold line low (after any frame in progress)
//   txd_tx                : registered serial line
//   tx_busy               : not IDLE
//   tx_bit_indicator      : last tick of each bit
//   tx_frame_indicator    : 00 idle/break, else alternates 10/01 per frame
module uart_tx_ctl_cfg
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_tx,
  input  logic                 rst_clk_tx_n,
  input  logic                 baud_en,
  input  logic                 char_fifo_empty,
  input  logic [DATA_BITS-1:0] char_fifo_dout,
  output logic                 char_fifo_rd_en,
  input  logic                 tx_break,
  output logic                 txd_tx,
  output logic                 tx_busy,
  output logic                 tx_bit_indicator,
  output logic [1:0]           tx_frame_indicator
);

  localparam int BW = $clog2(DATA_BITS);

  tx_state_t            state;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 pop_flag;
  logic [1:0]           last_frame;
  logic                 os_done;
  logic                 os_load;
  logic                 last_data;
  logic                 last_stop;
  logic                 in_frame;

  assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));
  assign in_frame  = (state == S_START) || (state == S_DATA) ||
                     (state == S_PAR)   || (state == S_STOP);

  // Reload on every state entry and every new bit; a STOP that falls back to
  // IDLE does not reload, so the counter rests at 0 while idle.
  always_comb begin
    os_load = 1'b0;
    case (state)
      S_IDLE:                 os_load = tx_break | ~char_fifo_empty;
      S_START, S_DATA, S_PAR: os_load = os_done;
      S_STOP:                 os_load = os_done & (~last_stop | tx_break | ~char_fifo_empty);
      S_BRK:                  os_load = ~tx_break;
      default:                os_load = 1'b0;
    endcase
  end

  uart_os_cnt #(.OVERSAMPLE(OVERSAMPLE)) u_os_cnt (
    .clk   (clk_tx),
    .rst_n (rst_clk_tx_n),
    .tick  (baud_en),
    .load  (os_load),
    .done  (os_done)
  );

  // pop_flag lives for exactly one tick period, so gating with baud_en
  // yields a single-cycle pop even when baud_en is tied high.
  assign char_fifo_rd_en  = pop_flag & baud_en;
  assign tx_bit_indicator = baud_en & os_done & in_frame;

  always_ff @(posedge clk_tx) begin
    if (!rst_clk_tx_n) begin
      state              <= S_IDLE;
      bit_cnt            <= '0;
      shift              <= '0;
      par_bit            <= 1'b0;
      pop_flag           <= 1'b0;
      txd_tx             <= 1'b1;
      tx_busy            <= 1'b0;
      tx_frame_indicator <= FRAME_IDLE;
      last_frame         <= FRAME_01;
    end else if (baud_en) begin
      pop_flag <= 1'b0;

      // Line follows the state of the previous tick.
      case (state)
        S_START, S_BRK: txd_tx <= 1'b0;
        S_DATA:         txd_tx <= shift[0];
        S_PAR:          txd_tx <= par_bit;
        default:        txd_tx <= 1'b1;
      endcase

      case (state)
        S_IDLE: begin
          if (tx_break) begin
            state              <= S_BRK;
            tx_busy            <= 1'b1;
            tx_frame_indicator <= FRAME_IDLE;
          end else if (!char_fifo_empty) begin
            state              <= S_START;
            tx_busy            <= 1'b1;
            shift              <= char_fifo_dout;
            par_bit            <= (^char_fifo_dout) ^ (PARITY == PAR_ODD);
            tx_frame_indicator <= frame_next(last_frame);
            last_frame         <= frame_next(last_frame);
          end
        end
        S_START: if (os_done) begin
          state   <= S_DATA;
          bit_cnt <= '0;
        end
        S_DATA: if (os_done) begin
          if (last_data) begin
            pop_flag <= 1'b1;
            bit_cnt  <= '0;
            state    <= (PARITY != PAR_NONE) ? S_PAR : S_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= shift >> 1;
          end
        end
        S_PAR: if (os_done) begin
          state   <= S_STOP;
          bit_cnt <= '0;
        end
        S_STOP: if (os_done) begin
          if (!last_stop) begin
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            bit_cnt <= '0;
            if (tx_break) begin
              state              <= S_BRK;
              tx_frame_indicator <= FRAME_IDLE;
            end else if (!char_fifo_empty) begin
              state              <= S_START;
              shift              <= char_fifo_dout;
              par_bit            <= (^char_fifo_dout) ^ (PARITY == PAR_ODD);
              tx_frame_indicator <= frame_next(last_frame);
              last_frame         <= frame_next(last_frame);
            end else begin
              state              <= S_IDLE;
              tx_busy            <= 1'b0;
              tx_frame_indicator <= FRAME_IDLE;
            end
          end
        end
        // Leaving a break always passes through one full stop period.
        S_BRK: if (!tx_break) begin
          state   <= S_STOP;
          bit_cnt <= '0;
        end
        default: begin
          state   <= S_IDLE;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctl_cfg.sv
// Directed bench for uart_tx_ctl_cfg. Four instances:
//   u0 : 8N1, OS=16, baud_en every 4 clocks
//   u1 : 7 data, even parity, 2 stop
//   u2 : 7 data, odd parity, 2 stop
//   u3 : 8N1, OS=4, baud_en tied high
module tb_uart_tx_ctl_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [1:0] bdiv  = 2'd0;
  logic       baud_a;
  always @(posedge clk) bdiv <= bdiv + 2'd1;
  assign baud_a = (bdiv == 2'd3);

  logic [3:0] baud;
  assign baud = {1'b1, {3{baud_a}}};

  logic [3:0] brk = 4'b0;
  wire  [3:0] txd, busy, rd, bi;
  wire  [1:0] fi [4];

  // Per-instance FIFO models (FWFT)
  logic [7:0] mem [4][16];
  int         wp [4] = '{default:0};
  int         rp [4] = '{default:0};
  logic [3:0] empty;
  logic [7:0] head [4];
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty[i] = (wp[i] == rp[i]);
      head[i]  = mem[i][rp[i] % 16];
    end
  end

  // Monitors
  int         pops [4] = '{default:0};
  int         wide [4] = '{default:0};
  int         bic  [4] = '{default:0};
  int         bsy  [4] = '{default:0};
  logic [3:0] rd_q    = 4'b0;
  logic [1:0] fi_prev = 2'b00;
  logic [1:0] fi_log [64];
  int         fi_n    = 0;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rd[i]) begin
        pops[i] <= pops[i] + 1;
        rp[i]   <= rp[i] + 1;
      end
      if (rd[i] && rd_q[i]) wide[i] <= wide[i] + 1;
      if (bi[i])            bic[i]  <= bic[i] + 1;
      if (busy[i])          bsy[i]  <= bsy[i] + 1;
    end
    rd_q <= rd;
    if (fi[0] !== fi_prev) begin
      fi_log[fi_n % 64] <= fi[0];
      fi_n <= fi_n + 1;
    end
    fi_prev <= fi[0];
  end

  uart_tx_ctl_cfg u0 (
    .clk_tx(clk), .rst_clk_tx_n(rst_n), .baud_en(baud[0]),
    .char_fifo_empty(empty[0]), .char_fifo_dout(head[0]), .char_fifo_rd_en(rd[0]),
    .tx_break(brk[0]), .txd_tx(txd[0]), .tx_busy(busy[0]),
    .tx_bit_indicator(bi[0]), .tx_frame_indicator(fi[0]));

  uart_tx_ctl_cfg #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u1 (
    .clk_tx(clk), .rst_clk_tx_n(rst_n), .baud_en(baud[1]),
    .char_fifo_empty(empty[1]), .char_fifo_dout(head[1][6:0]), .char_fifo_rd_en(rd[1]),
    .tx_break(brk[1]), .txd_tx(txd[1]), .tx_busy(busy[1]),
    .tx_bit_indicator(bi[1]), .tx_frame_indicator(fi[1]));

  uart_tx_ctl_cfg #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk_tx(clk), .rst_clk_tx_n(rst_n), .baud_en(baud[2]),
    .char_fifo_empty(empty[2]), .char_fifo_dout(head[2][6:0]), .char_fifo_rd_en(rd[2]),
    .tx_break(brk[2]), .txd_tx(txd[2]), .tx_busy(busy[2]),
    .tx_bit_indicator(bi[2]), .tx_frame_indicator(fi[2]));

  uart_tx_ctl_cfg #(.OVERSAMPLE(4)) u3 (
    .clk_tx(clk), .rst_clk_tx_n(rst_n), .baud_en(baud[3]),
    .char_fifo_empty(empty[3]), .char_fifo_dout(head[3]), .char_fifo_rd_en(rd[3]),
    .tx_break(brk[3]), .txd_tx(txd[3]), .tx_busy(busy[3]),
    .tx_bit_indicator(bi[3]), .tx_frame_indicator(fi[3]));

  int total = 0;
  int bad   = 0;

  // ---------------- stimulus / measurement helpers ----------------
  // Advance to just after the next baud tick seen by instance idx.
  task automatic tick(input int idx);
    int g;
    if (idx == 3) begin
      @(posedge clk); #1;
    end else begin
      g = 0;
      @(negedge clk);
      while (!baud_a && g < 16) begin
        @(negedge clk);
        g++;
      end
      @(posedge clk); #1;
    end
  endtask

  // Sample n ticks of txd; v = first value, steady = all samples equal.
  task automatic sample_bit(input int idx, input int n, output logic v, output logic steady);
    tick(idx);
    v = txd[idx];
    steady = 1'b1;
    for (int k = 1; k < n; k++) begin
      tick(idx);
      if (txd[idx] !== v) steady = 1'b0;
    end
  endtask

  // Wait for the first low tick of a start bit (consumes that tick).
  task automatic wait_start(input int idx, output logic found);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      tick(idx);
      if (txd[idx] === 1'b0) found = 1'b1;
    end
  endtask

  // Collect nb data bits of os ticks each, LSB first.
  task automatic grab_data(input int idx, input int nb, input int os,
                           output logic [7:0] d, output logic steady);
    logic v, s;
    d = 8'h00;
    steady = 1'b1;
    for (int k = 0; k < nb; k++) begin
      sample_bit(idx, os, v, s);
      d[k] = v;
      if (!s) steady = 1'b0;
    end
  endtask

  task automatic push(input int idx, input logic [7:0] d);
    mem[idx][wp[idx] % 16] = d;
    wp[idx] = wp[idx] + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    brk   = 4'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (txd !== 4'hF) begin bad++; $display("FAIL reset_txd got=%b want=1111", txd); end
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL reset_busy got=%b want=0000", busy); end
    total++; if (rd !== 4'h0) begin bad++; $display("FAIL reset_rd got=%b want=0000", rd); end
    total++; if (bi !== 4'h0) begin bad++; $display("FAIL reset_bitind got=%b want=0000", bi); end
    total++;
    if ({fi[0], fi[1], fi[2], fi[3]} !== 8'h00) begin
      bad++; $display("FAIL reset_frame got=%h want=00", {fi[0], fi[1], fi[2], fi[3]});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_8n1();
    logic f, v, s;
    logic [7:0] d;
    int p0, b0;
    do_reset();
    p0 = pops[0]; b0 = bic[0];
    push(0, 8'hA5);
    wait_start(0, f);
    total++; if (f !== 1'b1) begin bad++; $display("FAIL 8n1_start_seen got=%b want=1", f); end
    sample_bit(0, 15, v, s);
    total++; if ({s, v} !== 2'b10) begin bad++; $display("FAIL 8n1_start_bit got=%b want=10", {s, v}); end
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL 8n1_busy_mid got=%b want=1", busy[0]); end
    grab_data(0, 8, 16, d, s);
    total++; if ({s, d} !== 9'h1A5) begin bad++; $display("FAIL 8n1_data got=%h want=1a5", {s, d}); end
    sample_bit(0, 15, v, s);
    total++; if ({s, v, busy[0]} !== 3'b111) begin bad++; $display("FAIL 8n1_stop got=%b want=111", {s, v, busy[0]}); end
    tick(0);
    total++; if ({txd[0], busy[0]} !== 2'b10) begin bad++; $display("FAIL 8n1_idle got=%b want=10", {txd[0], busy[0]}); end
    total++; if (pops[0] - p0 !== 1) begin bad++; $display("FAIL 8n1_pops got=%0d want=1", pops[0] - p0); end
    total++; if (bic[0] - b0 !== 10) begin bad++; $display("FAIL 8n1_bitind got=%0d want=10", bic[0] - b0); end
  endtask

  task automatic test_parity();
    logic f, v, s;
    logic [7:0] d;
    for (int idx = 1; idx <= 2; idx++) begin
      do_reset();
      push(idx, 8'h41);
      wait_start(idx, f);
      sample_bit(idx, 15, v, s);
      total++; if ({f, s, v} !== 3'b110) begin bad++; $display("FAIL par%0d_start got=%b want=110", idx, {f, s, v}); end
      grab_data(idx, 7, 16, d, s);
      total++; if ({s, d} !== 9'h141) begin bad++; $display("FAIL par%0d_data got=%h want=141", idx, {s, d}); end
      sample_bit(idx, 16, v, s);
      total++;
      if ({s, v} !== {1'b1, (idx == 2)}) begin
        bad++; $display("FAIL par%0d_parity got=%b want=%b", idx, {s, v}, {1'b1, (idx == 2)});
      end
      sample_bit(idx, 31, v, s);
      total++; if ({s, v, busy[idx]} !== 3'b111) begin bad++; $display("FAIL par%0d_stop got=%b want=111", idx, {s, v, busy[idx]}); end
      tick(idx);
      total++; if ({txd[idx], busy[idx]} !== 2'b10) begin bad++; $display("FAIL par%0d_idle got=%b want=10", idx, {txd[idx], busy[idx]}); end
    end
  endtask

  task automatic test_back_to_back();
    logic f, v, s;
    logic [7:0] d;
    logic [7:0] bytes [3];
    int p0, f0;
    bytes[0] = 8'h11; bytes[1] = 8'hC3; bytes[2] = 8'h7E;
    do_reset();
    p0 = pops[0]; f0 = fi_n;
    for (int k = 0; k < 3; k++) push(0, bytes[k]);
    wait_start(0, f);
    total++; if (f !== 1'b1) begin bad++; $display("FAIL b2b_start_seen got=%b want=1", f); end
    for (int fr = 0; fr < 3; fr++) begin
      sample_bit(0, (fr == 0) ? 15 : 16, v, s);
      total++; if ({s, v} !== 2'b10) begin bad++; $display("FAIL b2b_start%0d got=%b want=10", fr, {s, v}); end
      grab_data(0, 8, 16, d, s);
      total++; if ({s, d} !== {1'b1, bytes[fr]}) begin bad++; $display("FAIL b2b_data%0d got=%h want=%h", fr, {s, d}, {1'b1, bytes[fr]}); end
      sample_bit(0, 16, v, s);
      total++; if ({s, v} !== 2'b11) begin bad++; $display("FAIL b2b_stop%0d got=%b want=11", fr, {s, v}); end
    end
    repeat (3) @(posedge clk);
    #1;
    total++; if (pops[0] - p0 !== 3) begin bad++; $display("FAIL b2b_pops got=%0d want=3", pops[0] - p0); end
    total++;
    if ({fi_n - f0 == 4, fi_log[f0 % 64], fi_log[(f0 + 1) % 64], fi_log[(f0 + 2) % 64], fi_log[(f0 + 3) % 64]} !== 9'b1_10_01_10_00) begin
      bad++;
      $display("FAIL b2b_frame_ind got=%0d:%b,%b,%b,%b want=4:10,01,10,00", fi_n - f0,
               fi_log[f0 % 64], fi_log[(f0 + 1) % 64], fi_log[(f0 + 2) % 64], fi_log[(f0 + 3) % 64]);
    end
  endtask

  task automatic test_break();
    logic f, v, s, s2;
    logic [7:0] d, d2;
    int p0, g;
    do_reset();
    p0 = pops[0];
    push(0, 8'h00);
    wait_start(0, f);
    sample_bit(0, 15, v, s);
    grab_data(0, 3, 16, d, s);
    brk[0] = 1'b1;
    grab_data(0, 5, 16, d2, s2);
    total++; if ({f, s, s2, d2[4:0], d[2:0]} !== 11'b111_00000_000) begin bad++; $display("FAIL brk_frame_data got=%b want=11100000000", {f, s, s2, d2[4:0], d[2:0]}); end
    sample_bit(0, 16, v, s);
    total++; if ({s, v} !== 2'b11) begin bad++; $display("FAIL brk_frame_stop got=%b want=11", {s, v}); end
    sample_bit(0, 40, v, s);
    total++; if ({s, v} !== 2'b10) begin bad++; $display("FAIL brk_hold got=%b want=10", {s, v}); end
    total++; if ({busy[0], fi[0]} !== 3'b100) begin bad++; $display("FAIL brk_status got=%b want=100", {busy[0], fi[0]}); end
    push(0, 8'hFF);
    brk[0] = 1'b0;
    sample_bit(0, 1, v, s);
    total++; if (v !== 1'b0) begin bad++; $display("FAIL brk_lag got=%b want=0", v); end
    sample_bit(0, 16, v, s);
    total++; if ({s, v} !== 2'b11) begin bad++; $display("FAIL brk_stop_after got=%b want=11", {s, v}); end
    sample_bit(0, 16, v, s);
    total++; if ({s, v} !== 2'b10) begin bad++; $display("FAIL brk_next_start got=%b want=10", {s, v}); end
    grab_data(0, 8, 16, d, s);
    total++; if ({s, d} !== 9'h1FF) begin bad++; $display("FAIL brk_next_data got=%h want=1ff", {s, d}); end
    g = 0;
    while (busy[0] && g < 40) begin tick(0); g++; end
    total++; if (pops[0] - p0 !== 2) begin bad++; $display("FAIL brk_pops got=%0d want=2", pops[0] - p0); end
  endtask

  task automatic test_reset_mid();
    logic f, v, s;
    logic [7:0] d;
    int p0;
    do_reset();
    p0 = pops[0];
    push(0, 8'h3C);
    wait_start(0, f);
    sample_bit(0, 15, v, s);
    grab_data(0, 2, 16, d, s);
    sample_bit(0, 5, v, s);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++; if ({txd[0], busy[0], rd[0]} !== 3'b100) begin bad++; $display("FAIL rmid_outputs got=%b want=100", {txd[0], busy[0], rd[0]}); end
    total++; if ({pops[0] - p0 == 0, empty[0]} !== 2'b10) begin bad++; $display("FAIL rmid_no_pop got=%0d,%b want=0,0", pops[0] - p0, empty[0]); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_start(0, f);
    sample_bit(0, 15, v, s);
    total++; if ({f, s, v} !== 3'b110) begin bad++; $display("FAIL rmid_resend_start got=%b want=110", {f, s, v}); end
    grab_data(0, 8, 16, d, s);
    total++; if ({s, d} !== 9'h13C) begin bad++; $display("FAIL rmid_resend_data got=%h want=13c", {s, d}); end
    sample_bit(0, 16, v, s);
    total++; if (pops[0] - p0 !== 1) begin bad++; $display("FAIL rmid_pops got=%0d want=1", pops[0] - p0); end
  endtask

  task automatic test_fast();
    logic f, v, s, s1;
    logic [7:0] d;
    int p0, w0, b0;
    do_reset();
    p0 = pops[3]; w0 = wide[3]; b0 = bsy[3];
    push(3, 8'hA5);
    wait_start(3, f);
    sample_bit(3, 3, v, s);
    total++; if ({f, s, v} !== 3'b110) begin bad++; $display("FAIL fast_start got=%b want=110", {f, s, v}); end
    grab_data(3, 8, 4, d, s);
    total++; if ({s, d} !== 9'h1A5) begin bad++; $display("FAIL fast_data got=%h want=1a5", {s, d}); end
    sample_bit(3, 4, v, s1);
    total++; if ({s1, v, busy[3]} !== 3'b110) begin bad++; $display("FAIL fast_stop got=%b want=110", {s1, v, busy[3]}); end
    total++; if (bsy[3] - b0 !== 40) begin bad++; $display("FAIL fast_frame_len got=%0d want=40", bsy[3] - b0); end
    total++; if (pops[3] - p0 !== 1) begin bad++; $display("FAIL fast_pops got=%0d want=1", pops[3] - p0); end
    total++; if (wide[3] - w0 !== 0) begin bad++; $display("FAIL fast_rd_width got=%0d want=0", wide[3] - w0); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_break();
    test_reset_mid();
    test_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
